// File: rtl/mig_tt_sweep.sv
// Programmable majority-inverter-graph evaluator that sweeps all 2^N_IN input patterns and streams the truth table.
// Define MIG_TT_POPCOUNT_EN to add the ones_cnt output (count of accepted 1 bits).
module mig_tt_sweep #(
  parameter int N_IN    = 7,
  parameter int N_NODES = 8,
  parameter int SEL_W   = $clog2(N_IN + N_NODES + 1),
  localparam int AW     = $clog2(N_NODES),
  localparam int NW     = $clog2(N_NODES + 1),
  localparam int PW     = 3 * (SEL_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [PW-1:0]    prog_data,
  input  logic [NW-1:0]    num_nodes,
  input  logic [SEL_W-1:0] out_sel,
  input  logic             out_inv,
  input  logic             start,
  output logic             busy,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic             tt_bit,
  output logic [N_IN-1:0]  tt_index,
  output logic             done
`ifdef MIG_TT_POPCOUNT_EN
  ,
  output logic [N_IN:0]    ones_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, EMIT, DONE} state_t;

  state_t             state_reg;
  logic [PW-1:0]      prog_mem [N_NODES];
  logic [N_NODES-1:0] node_reg;
  logic [N_IN-1:0]    pattern_reg;
  logic [NW-1:0]      node_cnt_reg;
  logic [NW-1:0]      nn_reg;
  logic [SEL_W-1:0]   out_sel_reg;
  logic               out_inv_reg;

  logic [PW-1:0]      cur_prog;
  logic [2:0]         op_val;
  logic               maj_val;
  logic               out_val;
  logic [NW-1:0]      nn_clamp;
  logic               last_node;
  logic               last_pat;

  // Only nodes below 'limit' are valid sources; anything else (forward, self, out of range) reads 0.
  function automatic logic operand(input logic [SEL_W-1:0] sel, input logic [N_IN-1:0] pat,
                                   input logic [N_NODES-1:0] nodes, input logic [NW-1:0] limit);
    logic v;
    v = 1'b0;
    for (int j = 0; j < N_IN; j++)
      if (int'(sel) == j + 1) v = pat[j];
    for (int k = 0; k < N_NODES; k++)
      if (int'(sel) == N_IN + 1 + k && k < int'(limit)) v = nodes[k];
    return v;
  endfunction

  assign cur_prog = prog_mem[node_cnt_reg[AW-1:0]];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_op
      assign op_val[gi] = operand(cur_prog[gi*(SEL_W+1) +: SEL_W], pattern_reg, node_reg, node_cnt_reg)
                          ^ cur_prog[gi*(SEL_W+1) + SEL_W];
    end
  endgenerate

  assign maj_val   = (op_val[0] & op_val[1]) | (op_val[0] & op_val[2]) | (op_val[1] & op_val[2]);
  assign out_val   = operand(out_sel_reg, pattern_reg, node_reg, nn_reg) ^ out_inv_reg;
  assign nn_clamp  = (num_nodes > NW'(N_NODES)) ? NW'(N_NODES) : num_nodes;
  assign last_node = (node_cnt_reg == nn_reg - NW'(1));
  assign last_pat  = &pattern_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      node_reg     <= '0;
      pattern_reg  <= '0;
      node_cnt_reg <= '0;
      nn_reg       <= '0;
      out_sel_reg  <= '0;
      out_inv_reg  <= 1'b0;
      for (int i = 0; i < N_NODES; i++) prog_mem[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (prog_we) prog_mem[prog_addr] <= prog_data;
          if (start) begin
            nn_reg       <= nn_clamp;
            out_sel_reg  <= out_sel;
            out_inv_reg  <= out_inv;
            pattern_reg  <= '0;
            node_cnt_reg <= '0;
            state_reg    <= (nn_clamp == '0) ? EMIT : EVAL;
          end
        end
        EVAL: begin
          node_reg[node_cnt_reg[AW-1:0]] <= maj_val;
          if (last_node) begin
            node_cnt_reg <= '0;
            state_reg    <= EMIT;
          end else begin
            node_cnt_reg <= node_cnt_reg + NW'(1);
          end
        end
        EMIT: begin
          if (tt_ready) begin
            if (last_pat) begin
              state_reg <= DONE;
            end else begin
              pattern_reg <= pattern_reg + N_IN'(1);
              state_reg   <= (nn_reg == '0) ? EMIT : EVAL;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so they hold steady through a stall.
  assign busy     = (state_reg != IDLE);
  assign tt_valid = (state_reg == EMIT);
  assign tt_bit   = tt_valid & out_val;
  assign tt_index = pattern_reg;
  assign done     = (state_reg == DONE);

`ifdef MIG_TT_POPCOUNT_EN
  logic [N_IN:0] ones_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      ones_cnt_reg <= '0;
    else if (state_reg == IDLE && start)
      ones_cnt_reg <= '0;
    else if (state_reg == EMIT && tt_ready && out_val)
      ones_cnt_reg <= ones_cnt_reg + (N_IN+1)'(1);
  end

  assign ones_cnt = ones_cnt_reg;
`endif

endmodule

// File: tb/tb_mig_tt_sweep.sv
// Randomized self-checking bench for mig_tt_sweep against a software MIG model (N_IN=7, N_NODES=8).
module tb_mig_tt_sweep;
  localparam int N_IN = 7;
  localparam int NP   = 128;

  logic        clk = 1'b0;
  logic        rst, prog_we, out_inv, start, tt_ready;
  logic [2:0]  prog_addr;
  logic [14:0] prog_data;
  logic [3:0]  num_nodes, out_sel;
  logic        busy, tt_valid, tt_bit, done;
  logic [6:0]  tt_index;
`ifdef MIG_TT_POPCOUNT_EN
  logic [7:0]  ones_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic [14:0] prog_m [8];

  always #5 clk = ~clk;

  mig_tt_sweep dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .num_nodes(num_nodes), .out_sel(out_sel), .out_inv(out_inv), .start(start),
    .busy(busy), .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_bit(tt_bit),
    .tt_index(tt_index), .done(done)
`ifdef MIG_TT_POPCOUNT_EN
    , .ones_cnt(ones_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [14:0] enc(input int s0, input int i0, input int s1, input int i1,
                                      input int s2, input int i2);
    return {i2[0], s2[3:0], i1[0], s1[3:0], i0[0], s0[3:0]};
  endfunction

  function automatic bit src(input int sel, input int p, input bit [7:0] nv, input int lim);
    if (sel == 0) return 1'b0;
    if (sel <= N_IN) return bit'((p >> (sel - 1)) & 1);
    if (sel - N_IN - 1 < lim) return nv[sel - N_IN - 1];
    return 1'b0;
  endfunction

  // Evaluate the whole graph for one pattern from the mirrored program.
  function automatic bit model_bit(input int p, input int nn, input int osel, input bit oinv);
    bit [7:0]    nv;
    int          k, cnt;
    logic [14:0] w;
    nv = '0;
    k  = (nn > 8) ? 8 : nn;
    for (int i = 0; i < k; i++) begin
      cnt = 0;
      for (int g = 0; g < 3; g++) begin
        w = prog_m[i] >> (g * 5);
        cnt += int'(src(int'(w[3:0]), p, nv, i) ^ w[4]);
      end
      nv[i] = (cnt >= 2);
    end
    return src(osel, p, nv, k) ^ oinv;
  endfunction

  task automatic load(input int a, input logic [14:0] d);
    prog_we   = 1'b1;
    prog_addr = a[2:0];
    prog_data = d;
    prog_m[a] = d;
    @(posedge clk); #1;
    prog_we   = 1'b0;
  endtask

  task automatic run_sweep(input string name, input int nn, input int osel, input bit oinv,
                           input int ready_pct, input bit disturb, output logic [127:0] tt);
    int k, cyc, idx, first_cyc, done_cyc, exp_ones;
    logic prev_stall, pb;
    logic [6:0] pi;
    k = (nn > 8) ? 8 : nn;
    tt = '0; idx = 0; first_cyc = -1; done_cyc = -1; prev_stall = 1'b0; pb = 1'b0; pi = '0;
    exp_ones = 0;
    for (int p = 0; p < NP; p++) exp_ones += int'(model_bit(p, nn, osel, oinv));
    num_nodes = nn[3:0]; out_sel = osel[3:0]; out_inv = oinv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({name, ".busy_c1"}, busy, 1);
    while (cyc < 20000) begin
      if (prev_stall) begin
        check({name, ".stall_idx"}, tt_index, pi);
        check({name, ".stall_bit"}, tt_bit, pb);
      end
      if (tt_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        check({name, ".index"}, tt_index, idx);
        check({name, ".bit"}, tt_bit, model_bit(idx, nn, osel, oinv));
        tt_ready   = ($urandom_range(99) < ready_pct);
        prev_stall = !tt_ready;
        pi = tt_index; pb = tt_bit;
        if (tt_ready) begin
          if (idx < NP) tt[idx] = tt_bit;
          idx++;
        end
      end else begin
        tt_ready   = $urandom_range(1);
        prev_stall = 1'b0;
      end
      if (disturb && cyc == 3) begin
        start = 1'b1; num_nodes = 4'd0; out_inv = ~oinv;
        prog_we = 1'b1; prog_addr = 3'($urandom_range(7)); prog_data = 15'($urandom);
      end
      if (done) begin
        done_cyc = cyc;
`ifdef MIG_TT_POPCOUNT_EN
        check({name, ".ones_cnt"}, ones_cnt, exp_ones);
`endif
        if (disturb) start = 1'b1;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0; prog_we = 1'b0;
      cyc++;
    end
    check({name, ".done_seen"}, done_cyc >= 0, 1);
    check({name, ".bits_accepted"}, idx, NP);
    if (ready_pct >= 100) begin
      check({name, ".first_valid_cyc"}, first_cyc, k + 1);
      check({name, ".done_cyc"}, done_cyc, NP * (k + 1) + 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ".idle_after_done"}, busy, 0);
    check({name, ".done_one_cycle"}, done, 0);
    $display("sweep %s nodes=%0d out_sel=%0d inv=%0d bits=%0d done@%0d", name, k, osel, oinv, idx, done_cyc);
  endtask

  initial begin
    logic [127:0] tt;
    int n;
    logic seen;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; num_nodes = '0;
    out_sel = '0; out_inv = 1'b0; start = 1'b0; tt_ready = 1'b1;
    for (int a = 0; a < 8; a++) prog_m[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.tt_valid", tt_valid, 0);
    check("reset.tt_bit", tt_bit, 0);
    check("reset.done", done, 0);
    check("reset.tt_index", tt_index, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    load(0, enc(1, 0, 2, 0, 3, 0));
    run_sweep("maj3", 1, 8, 1'b0, 100, 1'b0, tt);
    check("maj3.tt8", tt[7:0], 8'hE8);
    load(0, enc(0, 0, 1, 0, 2, 0));
    run_sweep("and2", 1, 8, 1'b0, 100, 1'b0, tt);
    check("and2.tt8", tt[7:0], 8'h88);
    run_sweep("nand2", 1, 8, 1'b1, 100, 1'b0, tt);
    check("nand2.tt8", tt[7:0], 8'h77);
    run_sweep("wire_x2", 0, 3, 1'b0, 100, 1'b0, tt);
    check("wire_x2.tt8", tt[7:0], 8'hF0);
    load(0, enc(9, 0, 1, 0, 0, 1));
    run_sweep("fwd_ref", 2, 8, 1'b0, 100, 1'b0, tt);
    check("fwd_ref.tt8", tt[7:0], 8'hAA);

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 8; a++) load(a, 15'($urandom));
      run_sweep("rand4", 4, $urandom_range(8, 11), 1'($urandom), 50, 1'b1, tt);
      run_sweep("rand_clamp", 12, $urandom_range(15), 1'($urandom), 60, 1'b0, tt);
    end

    for (int a = 0; a < 8; a++) load(a, 15'($urandom));
    num_nodes = 4'd3; out_sel = 4'd10; out_inv = 1'b0; tt_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(tt_valid && tt_index == 7'd40) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst.reach_pattern40", n < 5000, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst.busy", busy, 0);
    check("rst.tt_valid", tt_valid, 0);
    check("rst.tt_index", tt_index, 0);
    check("rst.tt_bit", tt_bit, 0);
    check("rst.done", done, 0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("rst.no_done", seen, 0);
    for (int a = 0; a < 8; a++) prog_m[a] = '0;
    run_sweep("cleared", 2, 9, 1'b1, 100, 1'b0, tt);
    for (int a = 0; a < 8; a++) load(a, 15'($urandom));
    run_sweep("reload", 4, 11, 1'b0, 70, 1'b0, tt);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mig_tt_sweep.md
# mig_tt_sweep

Programmable majority-inverter-graph (MIG) evaluator that sweeps every input pattern of an N_IN-input function and streams out its truth table one bit per pattern. It replaces fixed, hand-wired majority networks for the 7-input classification flow: a network is loaded once, then swept with a single start pulse. It sits between the network loader (program port) and the truth-table packer/classifier (bit stream).

## Interface
- N_IN, 7, function input count; pattern bit j drives input xj
- N_NODES, 8, maximum majority nodes per program
- SEL_W, $clog2(N_IN+N_NODES+1), operand select width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- prog_we  in  1  program write strobe; honoured only in IDLE
- prog_addr  in  $clog2(N_NODES)  node index written
- prog_data  in  3*(SEL_W+1)  {inv2,sel2,inv1,sel1,inv0,sel0}; op0 in LSBs
- num_nodes  in  $clog2(N_NODES+1)  active node count, sampled on start
- out_sel  in  SEL_W  operand driving the output, sampled on start
- out_inv  in  1  output complement, sampled on start
- start  in  1  begin sweep; accepted only in IDLE
- busy  out  1  high outside IDLE
- tt_valid  out  1  truth-table bit available
- tt_ready  in  1  downstream accepts bit
- tt_bit  out  1  function value for pattern tt_index
- tt_index  out  N_IN  current input pattern
- done  out  1  one-cycle pulse after final bit accepted

## Operation
- Operand encoding: 0 = constant 0; 1..N_IN = x(sel-1); N_IN+1+k = node k. Effective operand = source XOR inv.
- Node k = MAJ(op0,op1,op2). References to node index >= k (self/forward) and out-of-range selects read 0.
- States: IDLE, EVAL, EMIT, DONE.
- IDLE: prog_we writes program RAM; start latches num_nodes/out_sel/out_inv, clears pattern to 0, node counter to 0 -> EVAL (-> EMIT if num_nodes==0).
- EVAL: evaluates one node per cycle in order 0..num_nodes-1, storing result in node register file; after last node -> EMIT.
- EMIT: tt_valid=1, tt_bit = operand(out_sel) XOR out_inv. Hold all outputs stable until tt_ready. On handshake: pattern==2^N_IN-1 -> DONE, else pattern+1, -> EVAL (or EMIT if num_nodes==0).
- DONE: done=1 for one cycle -> IDLE.
- start while busy and prog_we while busy: ignored. num_nodes > N_NODES clamps to N_NODES.
- Reset: state IDLE; busy, tt_valid, tt_bit, done = 0; tt_index = 0; program RAM and node registers cleared to 0.
- Reset mid-sweep: abort immediately, no done pulse, same values as above.

## Timing
- start sampled at cycle 0 in IDLE; busy high from cycle 1.
- With K = num_nodes and tt_ready held high: first tt_valid at cycle K+1; one bit every K+1 cycles; final handshake at cycle 2^N_IN*(K+1); done at cycle 2^N_IN*(K+1)+1; IDLE (busy low) cycle after.
- K=0: one bit per cycle, back-to-back.
- tt_ready low stalls EMIT indefinitely; no bit dropped or duplicated.
- start in the same cycle as done: ignored (not IDLE).

## Configuration
- MIG_TT_POPCOUNT_EN defined: adds output ones_cnt [N_IN:0], cleared on start and reset, incremented on each accepted tt_bit==1; valid and stable from done until next start.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- N_IN=3: node0 = MAJ(x0,x1,x2), num_nodes=1, out_sel=node0 -> bits for patterns 0..7 = 0xE8; done at cycle 17; ones_cnt=4 (with macro).
- N_IN=3: node0 = MAJ(0,x0,x1) -> 0x88; out_inv=1 -> 0x77.
- N_IN=3, num_nodes=0, out_sel=x2 -> 0xF0, one bit per cycle, done at cycle 9.
- Random tt_ready throttling on a 4-node 7-input program vs. software MIG model -> all 128 bits match, tt_bit/tt_index stable while stalled.
- rst asserted at pattern 40 -> next cycle busy=0, tt_valid=0, no done; new start with reloaded program sweeps correctly from pattern 0.
- start and prog_we while busy -> ignored; forward reference node0.sel0=node1 reads 0.
